// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the iterative radix-2 FFT core.
package fft_pkg;
  typedef enum logic [1:0] {LOAD = 2'd0, COMPUTE = 2'd1, UNLOAD = 2'd2} state_e;

  localparam real PI = 3.14159265358979323846;

  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < width; i++) r[5'(width - 1 - i)] = value[5'(i)];
    return r;
  endfunction

  // Interprets the low in_w bits of value as signed and clamps to an out_w-bit signed range.
  function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int in_w,
                                              input int out_w);
    logic signed [63:0] v, hi, lo;
    v  = (value <<< (64 - in_w)) >>> (64 - in_w);
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Rounded Q2.(tw_w-2) twiddle component: cos for im=0, -sin for im=1.
  function automatic int tw_gen(input int k, input int n, input int tw_w, input bit im);
    real ang, x;
    ang = 2.0 * PI * k / n;
    x   = im ? -$sin(ang) : $cos(ang);
    x   = x * (2.0 ** (tw_w - 2));
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction
endpackage

// File: rtl/fft_iterative_core_rom.sv
// Forward-transform twiddle ROM (W^k = cos - j sin), N/2 entries, combinational lookup.
module fft_twiddle_rom
  import fft_pkg::*;
#(
  parameter int N_POINTS = 64,
  parameter int LOG2_N   = 6,
  parameter int TW_WIDTH = 10
) (
  input  logic        [LOG2_N-2:0]   k_i,
  output logic signed [TW_WIDTH-1:0] w_re_o,
  output logic signed [TW_WIDTH-1:0] w_im_o
);
  logic signed [TW_WIDTH-1:0] rom_re[N_POINTS/2];
  logic signed [TW_WIDTH-1:0] rom_im[N_POINTS/2];

  for (genvar g = 0; g < N_POINTS / 2; g++) begin : g_rom
    localparam int RE = tw_gen(g, N_POINTS, TW_WIDTH, 1'b0);
    localparam int IM = tw_gen(g, N_POINTS, TW_WIDTH, 1'b1);
    assign rom_re[g] = TW_WIDTH'(RE);
    assign rom_im[g] = TW_WIDTH'(IM);
  end

  assign w_re_o = rom_re[k_i];
  assign w_im_o = rom_im[k_i];
endmodule

// File: rtl/fft_iterative_core.sv
// In-place radix-2 DIT FFT: bit-reversed load, one butterfly per clock, natural-order unload.
module fft_iterative_core
  import fft_pkg::*;
#(
  parameter int N_POINTS = 64,
  parameter int LOG2_N   = 6,
  parameter int D_WIDTH  = 16,
  parameter int TW_WIDTH = 10
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic signed [D_WIDTH-1:0] in_re_i,
  input  logic signed [D_WIDTH-1:0] in_im_i,
  input  logic                      inverse_i,
  input  logic                      scale_en_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic signed [D_WIDTH-1:0] out_re_o,
  output logic signed [D_WIDTH-1:0] out_im_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      overflow_o
);
  localparam int AW = LOG2_N;
  localparam int KW = LOG2_N - 1;
  localparam int SW = $clog2(LOG2_N);
  localparam int IW = D_WIDTH + 2;
  localparam int PW = D_WIDTH + TW_WIDTH + 1;
  localparam logic signed [PW-1:0] RND = PW'(1 << (TW_WIDTH - 3));

  state_e                    state_q, state_d;
  logic [AW-1:0]             cnt_q, cnt_d;
  logic [SW-1:0]             stage_q, stage_d;
  logic                      inv_q, inv_d, scl_q, scl_d, ovf_q, ovf_d;
  logic                      done_q, done_d, oval_q, oval_d;
  logic signed [D_WIDTH-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic signed [D_WIDTH-1:0] mem_re_q[N_POINTS];
  logic signed [D_WIDTH-1:0] mem_im_q[N_POINTS];

  logic [AW-1:0] span, j, p, q, rev_addr;
  logic [SW-1:0] kshift;
  logic [KW-1:0] k;
  logic signed [TW_WIDTH-1:0] w_re, w_im, w_im_c;
  logic signed [PW-1:0] wr_x, wi_x, br_x, bi_x, t_re_f, t_im_f;
  logic signed [IW-1:0] a_re_x, a_im_x, t_re_x, t_im_x;
  logic [D_WIDTH:0] r_pre, r_pim, r_qre, r_qim;
  logic load_we, bf_we, clamp;

  function automatic logic [D_WIDTH:0] fin(input logic signed [IW-1:0] v, input logic sh);
    logic signed [IW-1:0] s;
    logic signed [63:0]   r;
    s = sh ? (v >>> 1) : v;
    r = sat(64'(s), IW, D_WIDTH);
    return {r != 64'(s), D_WIDTH'(r)};
  endfunction

  fft_twiddle_rom #(.N_POINTS(N_POINTS), .LOG2_N(LOG2_N), .TW_WIDTH(TW_WIDTH)) u_rom (
    .k_i   (k),
    .w_re_o(w_re),
    .w_im_o(w_im)
  );

  always_comb begin
    span     = AW'(1) << stage_q;
    j        = cnt_q & (span - AW'(1));
    p        = (((cnt_q >> stage_q) << stage_q) << 1) | j;
    q        = p | span;
    kshift   = SW'(LOG2_N - 1) - stage_q;
    k        = KW'(j << kshift);
    rev_addr = AW'(bitrev(32'(cnt_q), AW));
    w_im_c   = inv_q ? -w_im : w_im;
    wr_x     = PW'(w_re);
    wi_x     = PW'(w_im_c);
    br_x     = PW'(mem_re_q[q]);
    bi_x     = PW'(mem_im_q[q]);
    t_re_f   = wr_x * br_x - wi_x * bi_x + RND;
    t_im_f   = wr_x * bi_x + wi_x * br_x + RND;
    t_re_x   = IW'(t_re_f >>> (TW_WIDTH - 2));
    t_im_x   = IW'(t_im_f >>> (TW_WIDTH - 2));
    a_re_x   = IW'(mem_re_q[p]);
    a_im_x   = IW'(mem_im_q[p]);
    r_pre    = fin(a_re_x + t_re_x, scl_q);
    r_pim    = fin(a_im_x + t_im_x, scl_q);
    r_qre    = fin(a_re_x - t_re_x, scl_q);
    r_qim    = fin(a_im_x - t_im_x, scl_q);
    clamp    = r_pre[D_WIDTH] | r_pim[D_WIDTH] | r_qre[D_WIDTH] | r_qim[D_WIDTH];
  end

  // state   | meaning
  // LOAD    | accept N samples, stored at bit-reversed addresses
  // COMPUTE | one butterfly per cycle, stage_q outer / cnt_q inner
  // UNLOAD  | present bins 0..N-1, advance on out handshake
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stage_d  = stage_q;
    inv_d    = inv_q;
    scl_d    = scl_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    oval_d   = oval_q;
    out_re_d = out_re_q;
    out_im_d = out_im_q;
    load_we  = 1'b0;
    bf_we    = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_valid_i) begin
          load_we = 1'b1;
          cnt_d   = cnt_q + AW'(1);
          if (cnt_q == '0) begin
            inv_d = inverse_i;
            scl_d = scale_en_i;
            ovf_d = 1'b0;
          end
          if (cnt_q == AW'(N_POINTS - 1)) begin
            state_d = COMPUTE;
            stage_d = '0;
          end
        end
      end
      COMPUTE: begin
        bf_we = 1'b1;
        if (clamp) ovf_d = 1'b1;
        if (cnt_q == AW'(N_POINTS / 2 - 1)) begin
          cnt_d = '0;
          if (stage_q == SW'(LOG2_N - 1)) begin
            // Address 0 is never touched by the final butterfly, so it is safe to read now.
            state_d  = UNLOAD;
            oval_d   = 1'b1;
            out_re_d = mem_re_q[0];
            out_im_d = mem_im_q[0];
          end else begin
            stage_d = stage_q + SW'(1);
          end
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      UNLOAD: begin
        if (out_ready_i) begin
          if (cnt_q == AW'(N_POINTS - 1)) begin
            state_d = LOAD;
            cnt_d   = '0;
            oval_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d    = cnt_q + AW'(1);
            out_re_d = mem_re_q[cnt_q + AW'(1)];
            out_im_d = mem_im_q[cnt_q + AW'(1)];
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= LOAD;
      cnt_q    <= '0;
      stage_q  <= '0;
      inv_q    <= 1'b0;
      scl_q    <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      oval_q   <= 1'b0;
      out_re_q <= '0;
      out_im_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stage_q  <= stage_d;
      inv_q    <= inv_d;
      scl_q    <= scl_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      oval_q   <= oval_d;
      out_re_q <= out_re_d;
      out_im_q <= out_im_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_we) begin
      mem_re_q[rev_addr] <= in_re_i;
      mem_im_q[rev_addr] <= in_im_i;
    end else if (bf_we) begin
      mem_re_q[p] <= r_pre[D_WIDTH-1:0];
      mem_im_q[p] <= r_pim[D_WIDTH-1:0];
      mem_re_q[q] <= r_qre[D_WIDTH-1:0];
      mem_im_q[q] <= r_qim[D_WIDTH-1:0];
    end
  end

  assign in_ready_o  = (state_q == LOAD);
  assign busy_o      = (state_q != LOAD);
  assign out_valid_o = oval_q;
  assign out_re_o    = out_re_q;
  assign out_im_o    = out_im_q;
  assign done_o      = done_q;
  assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_fft_iterative_core.sv
// Scoreboard bench: a plain-arithmetic FFT model predicts every bin; a monitor pops and compares.
module tb_fft_iterative_core;
  localparam int N = 64;
  localparam int LG = 6;

  typedef int frame_t[N];
  typedef struct {
    int re;
    int im;
    bit ov;
    bit last;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, inverse = 1'b0, scale_en = 1'b0, out_ready = 1'b1;
  logic signed [15:0] in_re = '0, in_im = '0;
  logic in_ready, out_valid, busy, done, overflow;
  logic signed [15:0] out_re, out_im;

  int errors = 0, checks = 0, n_pushed = 0, n_popped = 0;
  bit bp = 1'b0;
  exp_t sbq[$];
  longint tw_r[N/2], tw_i[N/2];

  fft_iterative_core dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_re_i(in_re), .in_im_i(in_im), .inverse_i(inverse), .scale_en_i(scale_en),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_re_o(out_re), .out_im_o(out_im),
    .busy_o(busy), .done_o(done), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int brev(input int v);
    int r = 0;
    for (int b = 0; b < LG; b++) if (v & (1 << b)) r |= 1 << (LG - 1 - b);
    return r;
  endfunction

  function automatic longint clip(input longint v, inout bit ov);
    if (v > 32767) begin ov = 1'b1; return 32767; end
    if (v < -32768) begin ov = 1'b1; return -32768; end
    return v;
  endfunction

  // Textbook iterative DIT FFT on a bit-reversed copy, with the engine's fixed-point rules.
  function automatic void model(input frame_t xr, input frame_t xi, input bit inv, input bit scl,
                                output frame_t yr, output frame_t yi, output bit ov);
    longint ar[N], ai[N];
    ov = 1'b0;
    for (int n = 0; n < N; n++) begin
      ar[brev(n)] = xr[n];
      ai[brev(n)] = xi[n];
    end
    for (int s = 0; s < LG; s++) begin
      int span = 1 << s;
      for (int g = 0; g < N; g += 2 * span) begin
        for (int jj = 0; jj < span; jj++) begin
          int pp = g + jj, qq = g + jj + span, kk = jj * (N / (2 * span));
          longint wr = tw_r[kk], wi = inv ? -tw_i[kk] : tw_i[kk];
          longint tr = (wr * ar[qq] - wi * ai[qq] + 128) >>> 8;
          longint ti = (wr * ai[qq] + wi * ar[qq] + 128) >>> 8;
          longint sr = ar[pp] + tr, si = ai[pp] + ti, dr = ar[pp] - tr, di = ai[pp] - ti;
          if (scl) begin sr = sr >>> 1; si = si >>> 1; dr = dr >>> 1; di = di >>> 1; end
          ar[pp] = clip(sr, ov); ai[pp] = clip(si, ov);
          ar[qq] = clip(dr, ov); ai[qq] = clip(di, ov);
        end
      end
    end
    for (int n = 0; n < N; n++) begin
      yr[n] = int'(ar[n]);
      yi[n] = int'(ai[n]);
    end
  endfunction

  task automatic push_frame(input frame_t yr, input frame_t yi, input bit ov);
    exp_t e;
    for (int n = 0; n < N; n++) begin
      e.re = yr[n]; e.im = yi[n]; e.ov = ov; e.last = (n == N - 1);
      sbq.push_back(e);
      n_pushed++;
    end
  endtask

  task automatic send_frame(input frame_t xr, input frame_t xi, input bit inv, input bit scl,
                            input bit chk_clr);
    int i = 0, guard = 0;
    bit clr_done = 1'b0;
    while (i < N) begin
      @(posedge clk); #1;
      in_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      in_re = 16'(xr[i]); in_im = 16'(xi[i]);
      inverse = inv; scale_en = scl;
      @(negedge clk);
      if (chk_clr && i == 1 && !clr_done) begin
        chk("overflow_cleared", overflow, 0);
        clr_done = 1'b1;
      end
      if (in_valid && in_ready) i++;
      guard++;
      if (guard > 20000) begin
        $display("FAIL load_timeout: got %0d samples accepted, expected %0d", i, N);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    inverse = ~inv; scale_en = ~scl;
  endtask

  task automatic run_frame(input frame_t xr, input frame_t xi, input bit inv, input bit scl,
                           input bit chk_clr);
    frame_t yr, yi;
    bit ov;
    model(xr, xi, inv, scl, yr, yi, ov);
    push_frame(yr, yi, ov);
    send_frame(xr, xi, inv, scl, chk_clr);
  endtask

  task automatic drain();
    int g = 0;
    while (sbq.size() != 0 && g < 20000) begin @(negedge clk); g++; end
    chk("drain_queue_empty", sbq.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic impulse_frame();
    frame_t xr, xi, er, ei;
    for (int n = 0; n < N; n++) begin
      xr[n] = (n == 0) ? 1000 : 0; xi[n] = 0;
      er[n] = 1000; ei[n] = 0;
    end
    push_frame(er, ei, 1'b0);
    send_frame(xr, xi, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: pops one expectation per output handshake, and tracks the done pulse.
  initial begin
    exp_t e;
    bit exp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_done = 1'b0;
        continue;
      end
      if (done || exp_done) begin
        chk("done_pulse", done, exp_done);
        if (exp_done) chk("in_ready_at_done", in_ready, 1);
      end
      exp_done = 1'b0;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_bin", 1, 0);
        end else begin
          e = sbq.pop_front();
          n_popped++;
          chk("bin_re", out_re, e.re);
          chk("bin_im", out_im, e.im);
          chk("overflow_in_unload", overflow, e.ov);
          chk("busy_in_unload", busy, 1);
          if (e.last) exp_done = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    frame_t xr, xi, yr, yi;
    bit ov;
    for (int k = 0; k < N / 2; k++) begin
      real a;
      a = 2.0 * 3.141592653589793 * k / N;
      tw_r[k] = longint'($floor($cos(a) * 256.0 + 0.5));
      tw_i[k] = -longint'($floor($sin(a) * 256.0 + 0.5));
    end

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge clk); #1 rst = 1'b0;

    impulse_frame();

    for (int n = 0; n < N; n++) begin xr[n] = 256; xi[n] = 0; end
    run_frame(xr, xi, 1'b0, 1'b1, 1'b0);

    for (int n = 0; n < N; n++) begin xr[n] = (n % 2 == 0) ? 512 : -512; xi[n] = 0; end
    model(xr, xi, 1'b0, 1'b1, yr, yi, ov);
    run_frame(xr, xi, 1'b0, 1'b1, 1'b0);
    run_frame(yr, yi, 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < N; n++) begin xr[n] = 20000; xi[n] = 0; end
    run_frame(xr, xi, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < N; n++) begin
      xr[n] = int'($urandom_range(0, 2000)) - 1000;
      xi[n] = int'($urandom_range(0, 2000)) - 1000;
    end
    run_frame(xr, xi, 1'b0, 1'b1, 1'b1);

    bp = 1'b1;
    for (int f = 0; f < 3; f++) begin
      int amp = (f == 2) ? 32767 : 4000;
      for (int n = 0; n < N; n++) begin
        xr[n] = int'($urandom_range(0, 2 * amp)) - amp;
        xi[n] = int'($urandom_range(0, 2 * amp)) - amp;
      end
      run_frame(xr, xi, 1'($urandom_range(0, 1)), (f == 2) ? 1'b0 : 1'b1, 1'b0);
    end
    drain();
    bp = 1'b0;

    for (int n = 0; n < N; n++) begin xr[n] = (n == 0) ? 1000 : 0; xi[n] = 0; end
    send_frame(xr, xi, 1'b0, 1'b0, 1'b0);
    repeat (99) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    @(posedge clk); #1 rst = 1'b0;

    impulse_frame();
    drain();

    chk("bins_popped", n_popped, n_pushed);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fft_iterative_core.md
# fft_iterative_core

Parametrised, in-place, radix-2 decimation-in-time FFT engine that processes one N-point frame through three phases: load, compute and unload. Samples stream in through a valid/ready port and are stored bit-reversed. The engine runs one butterfly per clock across all log2(N) stages, then streams the bins out in natural order. It succeeds the fixed 64-point butterfly datapath and adds:
- runtime inverse mode;
- per-stage scaling;
- saturation with a sticky overflow flag;
- back-pressured I/O.

## Interface
- N_POINTS, 64, transform length; power of two, 8..1024
- LOG2_N, 6, log2(N_POINTS)
- D_WIDTH, 16, signed sample width (real and imaginary each)
- TW_WIDTH, 10, signed twiddle width, format Q2.(TW_WIDTH-2)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  engine accepts a sample this cycle
- in_re, in_im  in  D_WIDTH each  input sample, signed
- inverse  in  1  1 = IFFT (conjugate twiddles); sampled with the first sample of a frame
- scale_en  in  1  1 = arithmetic shift right by 1 after every stage; sampled with the first sample
- out_valid  out  1  output bin valid
- out_ready  in  1  downstream accepts the bin
- out_re, out_im  out  D_WIDTH each  output bin, signed
- busy  out  1  high in COMPUTE and UNLOAD
- done  out  1  one-cycle pulse when the last bin is accepted
- overflow  out  1  sticky; a saturation occurred in the current frame

## Operation
- States:
  - LOAD: in_ready=1. Each accepted sample with index i is written to address bitrev(i). After N acceptances go to COMPUTE.
  - COMPUTE: in_ready=0. Counters are stage s (0..LOG2_N-1) and butterfly b (0..N/2-1).
    - span = 2^s; group = b / span; j = b mod span.
    - Pair addresses: p = group*2*span + j, q = p + span.
    - Twiddle index k = j * (N/(2*span)).
    - After the last butterfly of the last stage, go to UNLOAD.
  - UNLOAD: presents address 0..N-1 in order. The address advances only on out_valid & out_ready. After address N-1 is accepted, pulse done and return to LOAD.
- Twiddle W^k = cos(2πk/N) − j·sin(2πk/N). When inverse=1 the sine term is negated. No 1/N normalisation beyond scale_en.
- Butterfly, with a = mem[p] and b = mem[q]:
  - t = W·b. Compute full-precision products, add the rounding constant 2^(TW_WIDTH-3), then arithmetic shift right by TW_WIDTH-2.
  - a' = a + t and b' = a − t, computed at D_WIDTH+2 bits.
  - If scale_en: arithmetic shift right by 1 (truncation toward −∞), then saturate.
  - Else: saturate to [−2^(D_WIDTH-1), 2^(D_WIDTH-1)−1].
  - Any clamp sets overflow.
- overflow clears on acceptance of the first sample of the next frame. It holds through UNLOAD.
- inverse and scale_en are ignored after the first sample of a frame until the next LOAD.
- rst at any point:
  - state returns to LOAD and all counters go to 0;
  - stored data is discarded; memory contents are don't-care.
- Reset values: in_ready=1, out_valid=0, out_re=0, out_im=0, busy=0, done=0, overflow=0.

## Timing
- Load takes N accepted cycles. Gaps in in_valid stall the load with no loss.
- COMPUTE is entered the cycle after the N-th acceptance.
- Each butterfly is one cycle: a combinational read of p and q, with both results written on the same rising edge.
- Compute takes exactly (N/2)·LOG2_N cycles; 192 for N=64.
- out_valid rises the cycle after the final butterfly write.
- out_re and out_im are registered outputs. They stay stable while out_valid & !out_ready.
- Minimum frame time is N + (N/2)·LOG2_N + N cycles.
- in_valid during COMPUTE or UNLOAD is ignored (in_ready=0).
- done coincides with the cycle after the last handshake. in_ready returns to 1 in that same cycle.

## Structure
- Package fft_pkg holds:
  - the state enum (LOAD, COMPUTE, UNLOAD);
  - the function bitrev(value, width);
  - the function sat(value, in_w, out_w);
  - the twiddle-ROM generator function, which computes cos/sin at elaboration.
- Sub-module fft_twiddle_rom: N/2 entries, combinational lookup by k, outputs W_re and W_im. The engine applies the inverse conjugation outside the ROM.
- Sample storage: two N×D_WIDTH register arrays with 2 read ports and 2 write ports.

## Test plan
- Impulse, N=64, scale_en=0: x[0]=1000+0j, all others 0 → every bin = 1000+0j, overflow=0.
- DC, scale_en=1: all x = 256+0j → bin0 = 256±1, all other bins within ±1 of 0.
- Alternating ±512 real, scale_en=1 → bin32 = 512±1, others ≈0. Then feed the output back with inverse=1, scale_en=0 → x[n] recovered within ±2 (applies the gain-of-N/N convention).
- Overflow: DC 20000, scale_en=0 → bin0 = 32767, overflow=1 through UNLOAD. overflow clears on the first sample of the next frame.
- Back-pressure: random in_valid and out_ready (50%) → exactly 64 bins, natural order, no duplicates or drops. done is a single-cycle pulse.
- Reset mid-COMPUTE (cycle 100) → next cycle in_ready=1, busy=0, out_valid=0. A fresh impulse frame then produces the correct result.
